// File: rtl/rx_byte_assembler_pkg.sv
// ----------------------------------------------------------------------------
// Module  : rx_byte_assembler_pkg
// Brief   : Shared receive-path definitions: FSM state encodings, frame size.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package rx_byte_assembler_pkg;

  typedef enum logic [1:0] {
    RX_IDLE = 2'd0,
    RX_DATA = 2'd1,
    RX_STOP = 2'd2
  } rx_state_t;

  localparam int RX_BITS_PER_BYTE = 8;

endpackage

`default_nettype wire

// File: rtl/rx_byte_fifo.sv
// ----------------------------------------------------------------------------
// Module  : rx_byte_fifo
// Brief   : Synchronous byte FIFO with a registered head entry (0 when empty).
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rx_byte_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i_push,
  input  logic [7:0] i_push_data,
  input  logic       i_pop,
  output logic [7:0] o_head,
  output logic       o_full,
  output logic       o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic [7:0]    r_head;

  logic          w_pop;
  logic          w_push;
  logic [AW-1:0] w_rd_next;
  logic [CW-1:0] w_count_next;
  logic [7:0]    w_head_next;

  assign o_full  = (r_count == CW'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_head  = r_head;

  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign w_pop        = i_pop & ~o_empty;
  assign w_push       = i_push & (~o_full | w_pop);
  assign w_rd_next    = w_pop ? (r_rd_ptr + AW'(1)) : r_rd_ptr;
  assign w_count_next = r_count + CW'(w_push) - CW'(w_pop);

  always_comb begin
    w_head_next = '0;
    if (w_count_next == '0) begin
      w_head_next = '0;
    end else if (w_push && (w_rd_next == r_wr_ptr)) begin
      w_head_next = i_push_data;
    end else begin
      w_head_next = r_mem[w_rd_next];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_head   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_push_data;
        r_wr_ptr        <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_next;
      r_count  <= w_count_next;
      r_head   <= w_head_next;
    end
  end

endmodule

`default_nettype wire

// File: rtl/rx_byte_assembler.sv
// ----------------------------------------------------------------------------
// Module  : rx_byte_assembler
// Brief   : Assembles 8N1 frames from the rxpath bit stream, checks the stop
//           bit and buffers good bytes behind a valid/ready interface.
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module rx_byte_assembler
  import rx_byte_assembler_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic             clk_8mhz,
  input  logic             rst,
  input  logic             in_bit,
  input  logic             in_valid,
  input  logic             in_start,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             frame_err,
  output logic             overflow,
  output logic [CNT_W-1:0] frame_err_cnt,
  output logic [CNT_W-1:0] overflow_cnt
);

  rx_state_t  r_state;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_shift;

  logic w_stop_strobe;
  logic w_push;
  logic w_bad_stop;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_drop;

  // A start strobe always wins over a coincident bit strobe.
  assign w_stop_strobe = (r_state == RX_STOP) & in_valid & ~in_start;
  assign w_push        = w_stop_strobe & in_bit;
  assign w_bad_stop    = w_stop_strobe & ~in_bit;
  assign w_pop         = out_valid & out_ready;
  assign w_drop        = w_push & w_full & ~w_pop;
  assign out_valid     = ~w_empty;

  rx_byte_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk_8mhz),
    .rst         (rst),
    .i_push      (w_push),
    .i_push_data (r_shift),
    .i_pop       (w_pop),
    .o_head      (out_data),
    .o_full      (w_full),
    .o_empty     (w_empty)
  );

  always_ff @(posedge clk_8mhz or posedge rst) begin
    if (rst) begin
      r_state       <= RX_IDLE;
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      frame_err     <= 1'b0;
      overflow      <= 1'b0;
      frame_err_cnt <= '0;
      overflow_cnt  <= '0;
    end else begin
      frame_err <= w_bad_stop;
      overflow  <= w_drop;
      if (w_bad_stop && (frame_err_cnt != '1)) begin
        frame_err_cnt <= frame_err_cnt + CNT_W'(1);
      end
      if (w_drop && (overflow_cnt != '1)) begin
        overflow_cnt <= overflow_cnt + CNT_W'(1);
      end

      if (in_start) begin
        r_state   <= RX_DATA;
        r_bit_cnt <= '0;
        r_shift   <= '0;
      end else if (in_valid) begin
        case (r_state)
          RX_DATA: begin
            r_shift[r_bit_cnt] <= in_bit;
            if (r_bit_cnt == 3'(RX_BITS_PER_BYTE - 1)) begin
              r_state <= RX_STOP;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          RX_STOP: r_state <= RX_IDLE;
          RX_IDLE: r_state <= RX_IDLE;
          default: r_state <= RX_IDLE;
        endcase
      end
    end
  end

endmodule

`default_nettype wire
